// File: rtl/inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// inst_prefetch_queue
//
// Fetch-side instruction prefetcher. It sits between a variable-latency
// instruction memory and the fetch/decode pipeline register. It issues one
// sequential word fetch at a time and buffers up to DEPTH returned
// instructions, each tagged with its PC+4. It hands the head entry to decode
// under a valid/ready handshake. A redirect flushes the queue and restarts
// fetching at a new address.
//
// Ports
//   clk          : clock
//   reset        : asynchronous active-high reset
//   imem_req     : fetch request valid (held until imem_ready)
//   imem_addr    : fetch byte address, always word aligned
//   imem_ready   : memory accepts the request this cycle
//   imem_rvalid  : read data valid
//   imem_rdata   : returned instruction
//   deq_valid    : queue head valid
//   deq_inst     : head instruction (0 when empty)
//   deq_pc_plus4 : head PC+4 (0 when empty)
//   deq_ready    : decode consumes the head this cycle
//   redirect     : flush and restart fetch
//   redirect_pc  : new fetch address (bits[1:0] ignored)
//
// inst_prefetch_queue_chk holds the structural invariants as assertions. It
// is instantiated by the top and contributes no logic.
// -----------------------------------------------------------------------------

module inst_prefetch_queue_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic          clk,
  input logic          reset,
  input logic [CW-1:0] count_q,
  input logic          fsm_idle_s,
  input logic          enq_s,
  input logic          imem_req,
  input logic          imem_ready,
  input logic          redirect
);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Occupancy never exceeds the storage.
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_q <= CNT_FULL);

  // A request is only issued with no fetch outstanding.
  a_req_only_idle: assert property (@(posedge clk) disable iff (reset)
    imem_req |-> fsm_idle_s);

  // The credit scheme guarantees that a returning word always finds a slot.
  a_enq_has_room: assert property (@(posedge clk) disable iff (reset)
    enq_s |-> (count_q < CNT_FULL));

  // A stalled request stays up until accepted, unless a redirect intervenes.
  a_req_hold: assert property (@(posedge clk) disable iff (reset)
    (imem_req && !imem_ready) |=> (imem_req || redirect));

endmodule

module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        deq_valid,
  output logic [31:0] deq_inst,
  output logic [31:0] deq_pc_plus4,
  input  logic        deq_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // S_WAIT: live fetch outstanding. S_DISCARD: fetch outstanding, but a
  // redirect made its data stale, so it is dropped when it returns.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT    = 2'b01,
    S_DISCARD = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc4_mem_q  [DEPTH];

  logic          busy_s;
  logic          credit_ok_s;
  logic          accept_s;
  logic          enq_s;
  logic          deq_s;
  logic          fsm_idle_s;
  logic [1:0]    unused_redirect_lo_s;

  // Fetches are word aligned, so the low redirect bits carry no information.
  assign unused_redirect_lo_s = redirect_pc[1:0];

  // Credit, request generation and handshake qualifiers.
  always_comb begin
    fsm_idle_s  = (state_q == S_IDLE);
    busy_s      = !fsm_idle_s;
    // An outstanding fetch has a slot reserved for it, so the queue
    // cannot overflow when the word comes back.
    credit_ok_s = ((count_q + CW'(busy_s)) < CNT_FULL);
    if (!reset && fsm_idle_s && credit_ok_s && !redirect) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
    imem_addr = fetch_pc_q;
    accept_s  = imem_req && imem_ready;
    // Redirect cancels any enqueue or dequeue in its cycle.
    enq_s     = (state_q == S_WAIT) && imem_rvalid && !redirect;
    deq_valid = (count_q != {CW{1'b0}});
    deq_s     = deq_valid && deq_ready && !redirect;
  end

  // Head presentation; an empty queue shows a zero bubble.
  always_comb begin
    if (deq_valid) begin
      deq_inst     = inst_mem_q[rd_ptr_q];
      deq_pc_plus4 = pc4_mem_q[rd_ptr_q];
    end else begin
      deq_inst     = 32'h0000_0000;
      deq_pc_plus4 = 32'h0000_0000;
    end
  end

  // FSM next state and fetch address bookkeeping.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      S_IDLE: begin
        // A returning word here belongs to an abandoned fetch; ignore it.
        if (accept_s) begin
          state_d  = S_WAIT;
          req_pc_d = fetch_pc_q;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WAIT: begin
        // rvalid wins: with a concurrent redirect the data is dropped via
        // enq_s and no stale fetch is left outstanding.
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end else if (redirect) begin
          state_d = S_DISCARD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DISCARD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (accept_s) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // Queue pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0000_0000;
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage: instruction and its PC+4 are written together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= 32'h0000_0000;
        pc4_mem_q[i]  <= 32'h0000_0000;
      end
    end else if (enq_s) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc4_mem_q[wr_ptr_q]  <= req_pc_q + 32'd4;
    end
  end

  inst_prefetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .count_q    (count_q),
    .fsm_idle_s (fsm_idle_s),
    .enq_s      (enq_s),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .redirect   (redirect)
  );

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_prefetch_queue
//
// Self-checking bench for inst_prefetch_queue. A behavioural model (a queue
// of {inst, pc+4} words plus a "pending fetch" tag) predicts every output on
// every cycle. A memory responder with configurable latency returns data for
// accepted requests. Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------

module tb_inst_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          P_NONE   = 0;
  localparam int          P_LIVE   = 1;
  localparam int          P_STALE  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        deq_valid;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc_plus4;
  logic        deq_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .deq_valid    (deq_valid),
    .deq_inst     (deq_inst),
    .deq_pc_plus4 (deq_pc_plus4),
    .deq_ready    (deq_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_pc;
  int          m_pend;
  logic [63:0] m_q [$];

  // Memory responder state and knobs.
  bit          r_busy;
  int          r_lat;
  logic [31:0] r_addr;
  bit          rst_on;
  int          lat_fix;
  int          lat_max;
  bit          rand_data;
  int          spur_pct;

  function automatic void model_reset();
    m_fetch_pc = RESET_PC;
    m_req_pc   = 32'h0;
    m_pend     = P_NONE;
    m_q.delete();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs against
  // the model, then advance the model and responder at the rising edge.
  task automatic cycle(input bit rdy, input bit drdy, input bit redir, input logic [31:0] rpc);
    bit          resp_v, e_req, e_dv, acc, push, pop;
    logic [31:0] e_addr, e_inst, e_pc4;
    reset       = rst_on;
    imem_ready  = rdy;
    deq_ready   = drdy;
    redirect    = redir;
    redirect_pc = rpc;
    resp_v      = r_busy && (r_lat == 0);
    imem_rvalid = resp_v;
    imem_rdata  = $urandom;
    if (resp_v && !rand_data) imem_rdata = r_addr ^ 32'hA5A5_0000;
    if (!r_busy && ($urandom_range(99) < spur_pct)) imem_rvalid = 1'b1;
    if (rst_on) model_reset();
    #1;
    e_req  = !rst_on && (m_pend == P_NONE) &&
             ((m_q.size() + ((m_pend != P_NONE) ? 1 : 0)) < DEPTH) && !redir;
    e_addr = m_fetch_pc;
    e_dv   = (m_q.size() != 0);
    e_inst = e_dv ? m_q[0][63:32] : 32'h0;
    e_pc4  = e_dv ? m_q[0][31:0]  : 32'h0;
    chk("imem_req",     32'(imem_req),  32'(e_req));
    chk("imem_addr",    imem_addr,      e_addr);
    chk("deq_valid",    32'(deq_valid), 32'(e_dv));
    chk("deq_inst",     deq_inst,       e_inst);
    chk("deq_pc_plus4", deq_pc_plus4,   e_pc4);
    pop  = !rst_on && e_dv && drdy && !redir;
    push = !rst_on && (m_pend == P_LIVE) && imem_rvalid && !redir;
    acc  = e_req && rdy;
    @(posedge clk);
    if (rst_on) begin
      model_reset();
    end else if (redir) begin
      m_q.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
      if (m_pend != P_NONE) m_pend = imem_rvalid ? P_NONE : P_STALE;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({imem_rdata, m_req_pc + 32'd4});
      if ((m_pend != P_NONE) && imem_rvalid) m_pend = P_NONE;
      if (acc) begin
        m_req_pc   = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
        m_pend     = P_LIVE;
      end
    end
    if (resp_v) r_busy = 1'b0;
    else if (r_busy && (r_lat > 0)) r_lat--;
    if (acc) begin
      r_busy = 1'b1;
      r_addr = e_addr;
      r_lat  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(lat_max, 0));
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_on = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    rst_on = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; deq_ready = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    rst_on = 1'b1; lat_fix = 0; lat_max = 0; rand_data = 1'b0; spur_pct = 0;
    r_busy = 1'b0; r_lat = 0; r_addr = 32'h0;
    model_reset();
    @(negedge clk);

    // In-order fetch with a 1-cycle memory, then fill to DEPTH.
    apply_reset();
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_inst", deq_inst, 32'hA5A5_0000);
    chk("first_pc4", deq_pc_plus4, 32'h0000_0004);
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_addr", imem_addr, 32'h0000_0010);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("pop_req", 32'(imem_req), 32'd1);
    chk("pop_addr", imem_addr, 32'h0000_0010);
    chk("pop_inst", deq_inst, 32'hA5A5_0004);
    chk("pop_pc4", deq_pc_plus4, 32'h0000_0008);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect while a fetch is outstanding and 2 entries are queued.
    apply_reset();
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    lat_fix = 2;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    chk("redir_flush", 32'(deq_valid), 32'd0);
    lat_fix = 0;
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_drop", 32'(deq_valid), 32'd0);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_pc4", deq_pc_plus4, 32'h0000_0104);
    chk("redir_inst", deq_inst, 32'hA5A5_0100);

    // Redirect coinciding with rvalid and deq_ready; unaligned target.
    apply_reset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    chk("same_cyc_valid", 32'(deq_valid), 32'd0);
    chk("same_cyc_addr", imem_addr, 32'h0000_0200);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("same_cyc_pc4", deq_pc_plus4, 32'h0000_0204);

    // Memory stalls, then reset in the middle of an outstanding fetch.
    apply_reset();
    lat_fix = 3;
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall_req", 32'(imem_req), 32'd1);
    chk("stall_addr", imem_addr, 32'h0000_0000);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wait_addr", imem_addr, 32'h0000_0004);
    rst_on = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    rst_on = 1'b0;
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_rst_valid", 32'(deq_valid), 32'd0);
    chk("post_rst_addr", imem_addr, 32'h0000_0000);

    // Fetch address wraps past the top of the address space.
    apply_reset();
    lat_fix = 0;
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_valid", 32'(deq_valid), 32'd1);
    chk("wrap_pc4", deq_pc_plus4, 32'h0000_0000);
    chk("wrap_inst", deq_inst, 32'h5A5A_FFFC);

    // Randomized traffic against the model.
    apply_reset();
    lat_fix = -1; lat_max = 3; rand_data = 1'b1; spur_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      rst_on = ($urandom_range(299) == 0);
      cycle($urandom_range(3) != 0, $urandom_range(9) < 6,
            $urandom_range(19) == 0, $urandom);
    end
    rst_on = 1'b0;
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
